// File: rtl/rocker_pkg.sv
// ---------------------------------------------------------------------------
// rocker_pkg
// Shared types and widths for the rocker heartbeat path.
//   PERIOD_W  : width of a beat interval / averaged period in ms
//   SUM_W     : width of the running sum of AVG_DEPTH intervals
//   AVG_DEPTH : number of intervals in the running average
//   FILL_W    : width of the buffer occupancy counter
//   state_t   : meter FSM states
//   averageOf : converts a buffer sum into the truncated average
// ---------------------------------------------------------------------------
package rocker_pkg;

  localparam int PERIOD_W  = 11;
  localparam int SUM_W     = 13;
  localparam int AVG_DEPTH = 4;
  localparam int FILL_W    = 3;

  // IDLE: no reference beat yet. MEASURE: timing from the last accepted beat.
  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // AVG_DEPTH is a power of two, so the divide is a plain shift and the
  // average is truncated rather than rounded.
  function automatic logic [PERIOD_W-1:0] averageOf(input logic [SUM_W-1:0] sum);
    return PERIOD_W'(sum >> $clog2(AVG_DEPTH));
  endfunction

endpackage

// File: rtl/hartslag_sync.sv
// ---------------------------------------------------------------------------
// hartslag_sync
// Brings an asynchronous active-high pin into the clk domain and emits a
// one-cycle pulse for every rising edge. Generic enough for any slow
// asynchronous input.
//   clk     in  system clock
//   reset   in  synchronous, active-low reset
//   async_i in  raw asynchronous input
//   pulse_o out one-cycle pulse on each synchronized rising edge
// ---------------------------------------------------------------------------
module hartslag_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  // [0] and [1] form the two-flop synchronizer, [2] holds the previous
  // synchronized level for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/hartslag_meter.sv
// ---------------------------------------------------------------------------
// hartslag_meter
// Measures the time between heartbeat pulses in ms and reports the running
// average of the last four accepted intervals. Beats arriving too soon after
// the previous accepted beat are ignored; when no beat arrives before the
// timeout the meter reports loss of signal and waits for a fresh reference.
//   Parameters
//     TICK_DIV      clk cycles per 1 ms tick
//     MIN_MS        shortest accepted interval in ms
//     MAX_MS        timeout in ms (must stay below 2048)
//   Ports
//     clk           in  system clock
//     reset         in  synchronous, active-low reset
//     hartslagIngang in raw asynchronous heartbeat pulse, active-high
//     period        out averaged beat interval in ms
//     period_valid  out one-cycle strobe when period updates
//     locked        out high while four valid intervals are buffered
//     lost          out high after timeout until the next accepted beat
// ---------------------------------------------------------------------------
module hartslag_meter
  import rocker_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int MIN_MS   = 300,
  parameter int MAX_MS   = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hartslagIngang,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                lost
);

  localparam int                PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_MS);
  localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_MS);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(AVG_DEPTH);

  logic                beat;
  logic                tick;
  logic                timeout;
  logic                accept;
  logic [PERIOD_W-1:0] counterInc;
  logic [FILL_W-1:0]   fillInc;
  logic [SUM_W-1:0]    bufSum;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [PERIOD_W-1:0] counter_q, counter_d;
  logic [PERIOD_W-1:0] beatBuf_q [AVG_DEPTH];
  logic [PERIOD_W-1:0] beatBuf_d [AVG_DEPTH];
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                periodValid_q, periodValid_d;
  logic                avgPending_q, avgPending_d;

  hartslag_sync uSync (
    .clk     (clk),
    .reset   (reset),
    .async_i (hartslagIngang),
    .pulse_o (beat)
  );

  // The ms tick and the value the interval counter will hold after this
  // edge. Using the post-tick value for the accept decision means a beat
  // landing on a tick edge sees the full elapsed ms count, so N*TICK_DIV
  // cycles between beats measures exactly N.
  always_comb begin
    tick       = (prescaler_q == PRE_LAST);
    counterInc = (counter_q == MAX_CNT) ? counter_q : counter_q + PERIOD_W'(tick);
    fillInc    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    timeout    = (state_q == MEASURE) && (counter_q == MAX_CNT);
    accept     = (state_q == MEASURE) && beat && !timeout &&
                 (counterInc >= MIN_CNT) && (counterInc < MAX_CNT);
  end

  // Sum of the buffered intervals. The averager reads it one cycle after the
  // buffer update, so it always sees the freshly shifted contents.
  always_comb begin
    bufSum = '0;
    for (int i = 0; i < AVG_DEPTH; i++) begin
      bufSum = bufSum + SUM_W'(beatBuf_q[i]);
    end
  end

  // Next-state logic. Timeout is checked before the beat so a beat arriving
  // in the same cycle the counter sits at MAX_MS is discarded.
  always_comb begin
    state_d       = state_q;
    prescaler_d   = prescaler_q;
    counter_d     = counter_q;
    beatBuf_d     = beatBuf_q;
    fill_d        = fill_q;
    locked_d      = locked_q;
    lost_d        = lost_q;
    period_d      = period_q;
    periodValid_d = 1'b0;
    avgPending_d  = 1'b0;

    if (avgPending_q) begin
      period_d      = averageOf(bufSum);
      periodValid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (beat) begin
          prescaler_d = '0;
          counter_d   = '0;
          fill_d      = '0;
          locked_d    = 1'b0;
          lost_d      = 1'b0;
          state_d     = MEASURE;
        end
      end

      MEASURE: begin
        prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
        counter_d   = counterInc;

        if (timeout) begin
          lost_d        = 1'b1;
          fill_d        = '0;
          locked_d      = 1'b0;
          period_d      = '0;
          periodValid_d = 1'b0;
          state_d       = IDLE;
        end else if (accept) begin
          beatBuf_d[0] = counterInc;
          for (int i = 1; i < AVG_DEPTH; i++) begin
            beatBuf_d[i] = beatBuf_q[i-1];
          end
          fill_d      = fillInc;
          locked_d    = (fillInc == FILL_FULL);
          avgPending_d = (fillInc == FILL_FULL);
          prescaler_d = '0;
          counter_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops all
  // buffered intervals so a fresh set of beats is needed afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      prescaler_q   <= '0;
      counter_q     <= '0;
      for (int i = 0; i < AVG_DEPTH; i++) begin
        beatBuf_q[i] <= '0;
      end
      fill_q        <= '0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      period_q      <= '0;
      periodValid_q <= 1'b0;
      avgPending_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      counter_q     <= counter_d;
      beatBuf_q     <= beatBuf_d;
      fill_q        <= fill_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      period_q      <= period_d;
      periodValid_q <= periodValid_d;
      avgPending_q  <= avgPending_d;
    end
  end

  assign period       = period_q;
  assign period_valid = periodValid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_hartslag_meter.sv
// ---------------------------------------------------------------------------
// tb_hartslag_meter
// Self-checking bench for hartslag_meter with a 4-cycle ms tick, 10 ms
// minimum and 100 ms timeout. A reference model tracks accepted intervals
// from beat rise times in clk cycles (interval = cycles / TICK_DIV).
// ---------------------------------------------------------------------------
module tb_hartslag_meter;

  localparam int TICK  = 4;
  localparam int MINMS = 10;
  localparam int MAXMS = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        hartslagIngang;
  logic [10:0] period;
  logic        period_valid;
  logic        locked;
  logic        lost;

  hartslag_meter #(
    .TICK_DIV (TICK),
    .MIN_MS   (MINMS),
    .MAX_MS   (MAXMS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hartslagIngang (hartslagIngang),
    .period         (period),
    .period_valid   (period_valid),
    .locked         (locked),
    .lost           (lost)
  );

  always #5 clk = ~clk;

  // Number of rising clk edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Every period_valid strobe is logged with its cycle and value; the
  // strobe must never be high on two consecutive cycles.
  int   strobeCyc[$];
  int   strobeVal[$];
  logic prevValid = 1'b0;
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      strobeCyc.push_back(cyc);
      strobeVal.push_back(int'(period));
      compared++;
      if (prevValid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL strobe_consecutive: got previous valid=%b, expected 0 at cycle %0d", prevValid, cyc);
      end
    end
    prevValid = period_valid;
  end

  // Reference model state.
  bit refMeasure;
  int refLastAcc;
  int refBuf[$];
  bit refLost;
  int refPeriod;
  int lastRise;

  function automatic void modelReset();
    refMeasure = 1'b0;
    refBuf.delete();
    refLost    = 1'b0;
    refPeriod  = 0;
  endfunction

  task automatic modelBeat(input int rise, output bit es, output int ev);
    int d, ms, s;
    es = 1'b0;
    ev = 0;
    if (refMeasure) begin
      d = rise - refLastAcc;
      if (d > TICK*MAXMS + 1) begin
        refMeasure = 1'b0; refLost = 1'b1; refBuf.delete(); refPeriod = 0;
      end else if (d >= TICK*MAXMS) begin
        refMeasure = 1'b0; refLost = 1'b1; refBuf.delete(); refPeriod = 0;
        return;
      end else begin
        ms = d / TICK;
        if (ms >= MINMS) begin
          refBuf.push_back(ms);
          if (refBuf.size() > 4) void'(refBuf.pop_front());
          refLastAcc = rise;
          if (refBuf.size() == 4) begin
            s = 0;
            foreach (refBuf[i]) s += refBuf[i];
            refPeriod = s / 4;
            es = 1'b1;
            ev = refPeriod;
          end
        end
        return;
      end
    end
    refMeasure = 1'b1;
    refLastAcc = rise;
    refLost    = 1'b0;
    refBuf.delete();
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Raise the heartbeat pin 'gap' cycles after the previous rise, hold 3 cycles.
  task automatic applyStimulus(input int gap);
    waitCyc(lastRise + gap);
    hartslagIngang = 1'b1;
    lastRise = cyc;
    repeat (3) @(negedge clk);
    hartslagIngang = 1'b0;
  endtask

  task automatic collect(output int n, output int c, output int v);
    n = strobeCyc.size();
    c = -1;
    v = -1;
    while (strobeCyc.size() > 0) begin
      c = strobeCyc.pop_front();
      v = strobeVal.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hartslagIngang = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (period !== 11'd0 || period_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got period=%0d valid=%b locked=%b lost=%b, expected 0/0/0/0", period, period_valid, locked, lost);
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (period !== 11'd0 || period_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL after_reset: got period=%0d valid=%b locked=%b lost=%b, expected 0/0/0/0", period, period_valid, locked, lost);
    end
    modelReset();
    lastRise = cyc;
  endtask

  task automatic test_lock();
    int gaps[5] = '{10, 200, 200, 200, 200};
    int n, c, v, ev;
    bit es;
    foreach (gaps[k]) begin
      applyStimulus(gaps[k]);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if ((es && (n != 1 || c != lastRise + 4 || v != ev)) || (!es && n != 0)) begin
        mismatched++;
        $display("[TB] FAIL lock_strobe: got n=%0d at=+%0d val=%0d, expected n=%0d at=+4 val=%0d", n, c - lastRise, v, es, ev);
      end
      compared++;
      if (locked !== 1'(refBuf.size() == 4) || lost !== refLost || int'(period) != refPeriod) begin
        mismatched++;
        $display("[TB] FAIL lock_status: got locked=%b lost=%b period=%0d, expected %b/%b/%0d", locked, lost, period, refBuf.size() == 4, refLost, refPeriod);
      end
    end
  endtask

  task automatic test_ramp();
    int n, c, v, ev;
    bit es;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(240);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if (!es || n != 1 || c != lastRise + 4 || v != ev) begin
        mismatched++;
        $display("[TB] FAIL ramp_strobe: got n=%0d at=+%0d val=%0d, expected n=1 at=+4 val=%0d", n, c - lastRise, v, ev);
      end
    end
    compared++;
    if (period !== 11'd60 || locked !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ramp_final: got period=%0d locked=%b, expected 60/1", period, locked);
    end
  endtask

  task automatic test_glitch();
    int n, c, v, ev;
    bit es;
    applyStimulus(20);
    modelBeat(lastRise, es, ev);
    waitCyc(lastRise + 5);
    collect(n, c, v);
    compared++;
    if (n != 0 || es) begin
      mismatched++;
      $display("[TB] FAIL glitch_ignored: got %0d strobes, expected 0", n);
    end
    applyStimulus(180);
    modelBeat(lastRise, es, ev);
    waitCyc(lastRise + 5);
    collect(n, c, v);
    compared++;
    if (!es || n != 1 || v != ev || ev != 57) begin
      mismatched++;
      $display("[TB] FAIL glitch_next: got n=%0d val=%0d, expected n=1 val=57", n, v);
    end
  endtask

  task automatic test_timeout();
    int n, c, v, ev;
    bit es;
    waitCyc(lastRise + 403);
    compared++;
    if (lost !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_early: got lost=%b, expected 0", lost);
    end
    @(negedge clk);
    compared++;
    if (lost !== 1'b1 || period !== 11'd0 || locked !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_state: got lost=%b period=%0d locked=%b, expected 1/0/0", lost, period, locked);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 0 ? 500 : 200);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if ((es && (n != 1 || c != lastRise + 4 || v != ev)) || (!es && n != 0) || es != (k == 4)) begin
        mismatched++;
        $display("[TB] FAIL relock_strobe: beat %0d got n=%0d val=%0d, expected n=%0d val=%0d", k, n, v, es, ev);
      end
      compared++;
      if (lost !== refLost || locked !== 1'(refBuf.size() == 4)) begin
        mismatched++;
        $display("[TB] FAIL relock_status: got lost=%b locked=%b, expected %b/%b", lost, locked, refLost, refBuf.size() == 4);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n, c, v, ev;
    bit es;
    applyStimulus(TICK*MAXMS + 1);
    modelBeat(lastRise, es, ev);
    waitCyc(lastRise + 5);
    collect(n, c, v);
    compared++;
    if (n != 0 || lost !== 1'b1 || locked !== 1'b0 || period !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL simultaneous: got n=%0d lost=%b locked=%b period=%0d, expected 0/1/0/0", n, lost, locked, period);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(200);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if ((es && (n != 1 || v != ev)) || (!es && n != 0) || es != (k == 4)) begin
        mismatched++;
        $display("[TB] FAIL after_simultaneous: beat %0d got n=%0d val=%0d, expected n=%0d val=%0d", k, n, v, es, ev);
      end
    end
  endtask

  task automatic test_midreset();
    int n, c, v, ev;
    bit es;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(280);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if (n != 1 || v != ev || v != 55 + 5*k) begin
        mismatched++;
        $display("[TB] FAIL pre_reset_strobe: got n=%0d val=%0d, expected n=1 val=%0d", n, v, 55 + 5*k);
      end
    end
    waitCyc(lastRise + 100);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (period !== 11'd0 || period_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_values: got period=%0d valid=%b locked=%b lost=%b, expected 0/0/0/0", period, period_valid, locked, lost);
    end
    reset = 1'b1;
    modelReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 0 ? 300 : 200);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if ((es && (n != 1 || c != lastRise + 4 || v != ev)) || (!es && n != 0) || es != (k == 4)) begin
        mismatched++;
        $display("[TB] FAIL post_reset_strobe: beat %0d got n=%0d val=%0d, expected n=%0d val=%0d", k, n, v, es, ev);
      end
    end
  endtask

  task automatic test_random();
    int n, c, v, ev, gap;
    bit es;
    for (int k = 0; k < 40; k++) begin
      gap = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 60) : $urandom_range(60, 450);
      applyStimulus(gap);
      modelBeat(lastRise, es, ev);
      waitCyc(lastRise + 5);
      collect(n, c, v);
      compared++;
      if ((es && (n != 1 || c != lastRise + 4 || v != ev)) || (!es && n != 0)) begin
        mismatched++;
        $display("[TB] FAIL random_strobe: beat %0d gap %0d got n=%0d at=+%0d val=%0d, expected n=%0d val=%0d", k, gap, n, c - lastRise, v, es, ev);
      end
      compared++;
      if (locked !== 1'(refBuf.size() == 4) || lost !== refLost || int'(period) != refPeriod) begin
        mismatched++;
        $display("[TB] FAIL random_status: beat %0d got locked=%b lost=%b period=%0d, expected %b/%b/%0d", k, locked, lost, period, refBuf.size() == 4, refLost, refPeriod);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_ramp();
    test_glitch();
    test_timeout();
    test_simultaneous();
    test_midreset();
    test_random();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000000;
    mismatched++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
